// File: rtl/param_updown_counter.sv
// param_updown_counter: single-clock up/down counter with programmable modulus,
// direction, synchronous load (clamped to MOD-1) and wrap/saturate mode.
// tc is combinational; wrap is a registered one-cycle pulse after each wrap.
// Optional build macro COUNTER_STICKY_WRAP_EN adds wrap_clr / wrap_sticky.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 2 ** WIDTH,
  parameter int RESET_VAL = MOD - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
`ifdef COUNTER_STICKY_WRAP_EN
  ,
  input  logic             wrap_clr,
  output logic             wrap_sticky
`endif
);

  localparam logic [WIDTH-1:0] QMAX   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] QRESET = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   QMAX_X = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);

  // Limit a WIDTH+1 bit candidate to the legal range 0..MOD-1.
  function automatic logic [WIDTH-1:0] sat_to_mod(input logic [WIDTH:0] v);
    if (v > QMAX_X) begin
      return QMAX;
    end
    return v[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Next-state selection: load beats enable beats hold; bounds wrap or saturate.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = sat_to_mod({1'b0, load_val});
    end else if (en) begin
      if (up_dn) begin
        if (q == QMAX) begin
          if (!sat) begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          q_nxt = sat_to_mod({1'b0, q} + ONE_X);
        end
      end else begin
        if (q == '0) begin
          if (!sat) begin
            q_nxt    = QMAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          q_nxt = sat_to_mod({1'b0, q} - ONE_X);
        end
      end
    end
  end

  // Count register and wrap pulse; reset forces the start value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= QRESET;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign qbar = ~q;
  assign tc   = en & ((up_dn & (q == QMAX)) | (~up_dn & (q == '0)));

`ifdef COUNTER_STICKY_WRAP_EN
  // Sticky wrap flag: a new wrap wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_sticky <= 1'b0;
    end else if (wrap_nxt) begin
      wrap_sticky <= 1'b1;
    end else if (wrap_clr) begin
      wrap_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: two instances (MOD=16 default, MOD=10) share
// stimulus; each is compared against an arithmetic reference model.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat, load;
  logic [3:0] load_val;
  logic [3:0] q16, qbar16, q10, qbar10;
  logic       tc16, tc10, wrap16, wrap10;
`ifdef COUNTER_STICKY_WRAP_EN
  logic       wrap_clr;
  logic       ws16, ws10;
`endif

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .q(q16), .qbar(qbar16), .tc(tc16), .wrap(wrap16)
`ifdef COUNTER_STICKY_WRAP_EN
    , .wrap_clr(wrap_clr), .wrap_sticky(ws16)
`endif
  );

  param_updown_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .q(q10), .qbar(qbar10), .tc(tc10), .wrap(wrap10)
`ifdef COUNTER_STICKY_WRAP_EN
    , .wrap_clr(wrap_clr), .wrap_sticky(ws10)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: index 0 is MOD=16, index 1 is MOD=10.
  int mm[2] = '{16, 10};
  int mq[2];
  bit mw[2];
  bit ms[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = mm[i] - 1;
      mw[i] = 1'b0;
      ms[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      int nq;
      bit nw;
      nq = mq[i];
      nw = 1'b0;
      if (load) begin
        nq = (int'(load_val) > mm[i] - 1) ? mm[i] - 1 : int'(load_val);
      end else if (en) begin
        int t;
        t = up_dn ? mq[i] + 1 : mq[i] - 1;
        if (t >= 0 && t < mm[i]) nq = t;
        else if (!sat) begin
          nq = (t + mm[i]) % mm[i];
          nw = 1'b1;
        end
      end
`ifdef COUNTER_STICKY_WRAP_EN
      if (nw) ms[i] = 1'b1;
      else if (wrap_clr) ms[i] = 1'b0;
`endif
      mq[i] = nq;
      mw[i] = nw;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_tc(input int i);
    return int'(en && ((up_dn && mq[i] == mm[i] - 1) || (!up_dn && mq[i] == 0)));
  endfunction

  task automatic check_all(input string tag);
    check({tag, " q16"}, int'(q16), mq[0]);
    check({tag, " qbar16"}, int'(qbar16), 15 - mq[0]);
    check({tag, " tc16"}, int'(tc16), exp_tc(0));
    check({tag, " wrap16"}, int'(wrap16), int'(mw[0]));
    check({tag, " q10"}, int'(q10), mq[1]);
    check({tag, " qbar10"}, int'(qbar10), 15 - mq[1]);
    check({tag, " tc10"}, int'(tc10), exp_tc(1));
    check({tag, " wrap10"}, int'(wrap10), int'(mw[1]));
`ifdef COUNTER_STICKY_WRAP_EN
    check({tag, " sticky16"}, int'(ws16), int'(ms[0]));
    check({tag, " sticky10"}, int'(ws10), int'(ms[1]));
`endif
  endtask

  task automatic set_in(input bit ld, input bit e, input bit ud, input bit s, input int lv);
    load = ld; en = e; up_dn = ud; sat = s; load_val = 4'(lv);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit ld, e, ud, s;
    int lv;
    int eq16, eq10;
    bit ew16, ew10;
  } vec_t;

  vec_t tbl[18];

  initial begin
    rst = 1'b1;
`ifdef COUNTER_STICKY_WRAP_EN
    wrap_clr = 1'b0;
`endif
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_all("por");
    do_reset();

    // Directed vectors from reset (q16=15, q10=9).
    tbl[0]  = '{1, 1, 0, 0, 7,  7,  7, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0,  8,  8, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0,  9,  9, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 10,  0, 0, 1};
    tbl[4]  = '{0, 1, 1, 0, 0, 11,  1, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 12, 12, 9, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 12, 12, 9, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 0, 13,  9, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 14,  9, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 13,  8, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 12,  7, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 0, 12,  7, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0,  0,  0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 15,  9, 1, 1};
    tbl[14] = '{0, 1, 0, 0, 0, 14,  8, 0, 0};
    tbl[15] = '{1, 1, 0, 1, 15, 15, 9, 0, 0};
    tbl[16] = '{0, 1, 1, 0, 0,  0,  0, 1, 1};
    tbl[17] = '{0, 1, 1, 0, 0,  1,  1, 0, 0};
    for (int k = 0; k < 18; k++) begin
      set_in(tbl[k].ld, tbl[k].e, tbl[k].ud, tbl[k].s, tbl[k].lv);
      step("tbl");
      check("tbl q16 const", int'(q16), tbl[k].eq16);
      check("tbl q10 const", int'(q10), tbl[k].eq10);
      check("tbl w16 const", int'(wrap16), int'(tbl[k].ew16));
      check("tbl w10 const", int'(wrap10), int'(tbl[k].ew10));
    end

    // Down count from 15 through the wrap: 14..0,15,14.
    do_reset();
    set_in(0, 1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      step("down17");
      check("down17 q", int'(q16), (15 - k + 16) % 16);
      check("down17 wrap", int'(wrap16), int'(k == 16));
      check("down17 tc", int'(tc16), int'(k == 15));
    end

    // Asynchronous reset mid-cycle while wrap is high.
    set_in(1, 0, 0, 0, 0);
    step("prewrap load");
    set_in(0, 1, 0, 0, 0);
    step("prewrap wrap");
    check("prewrap wrap16 high", int'(wrap16), 1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async q16", int'(q16), 15);
    check("async qbar16", int'(qbar16), 0);
    check("async q10", int'(q10), 9);
    check("async wrap16", int'(wrap16), 0);
    check("async wrap10", int'(wrap10), 0);
    step("held in reset");
    #2;
    rst = 1'b0;
    step("first after reset");
    check("post-reset q16", int'(q16), 14);
    check("post-reset q10", int'(q10), 8);

`ifdef COUNTER_STICKY_WRAP_EN
    do_reset();
    set_in(1, 0, 0, 0, 0);
    step("st load");
    set_in(0, 1, 0, 0, 0);
    step("st wrap");
    set_in(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step("st hold");
      check("sticky persists", int'(ws16), 1);
    end
    set_in(1, 0, 0, 0, 0);
    step("st reload");
    set_in(0, 1, 0, 0, 0);
    wrap_clr = 1'b1;
    step("st set+clr");
    check("sticky set wins", int'(ws16), 1);
    set_in(0, 0, 0, 0, 0);
    step("st clr");
    check("sticky cleared", int'(ws16), 0);
    wrap_clr = 1'b0;
`endif

    // Randomized stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
`ifdef COUNTER_STICKY_WRAP_EN
      wrap_clr = ($urandom_range(0, 7) == 0);
`endif
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
